// File: rtl/cpu16_pkg.sv
// Shared cpu16 definitions: datapath widths, fetch FSM encoding and default reset vector.
package cpu16_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      FS_HI,
      FS_LO,
      FS_OUT
   } fetch_state_e;

endpackage

// File: rtl/ifetch_seq_if.sv
// Fetch sequencer bus: byte-wide instruction memory port, branch redirect and ir handoff.
interface ifetch_seq_if
   import cpu16_pkg::*;
#(
   parameter int unsigned PC_W   = 16,
   parameter int unsigned ICNT_W = 16
);

   logic [PC_W-1:0]    mem_addr;
   logic               mem_rd;
   logic [BYTE_W-1:0]  mem_data;
   logic               mem_rdy;
   logic               br_valid;
   logic [PC_W-1:0]    br_target;
   logic [INSTR_W-1:0] ir;
   logic [PC_W-1:0]    ir_pc;
   logic               ir_valid;
   logic               ir_ready;
   logic [PC_W-1:0]    pc;
   logic [ICNT_W-1:0]  icnt;

   modport master (
      output mem_addr, mem_rd, ir, ir_pc, ir_valid, pc, icnt,
      input  mem_data, mem_rdy, br_valid, br_target, ir_ready
   );

   modport slave (
      input  mem_addr, mem_rd, ir, ir_pc, ir_valid, pc, icnt,
      output mem_data, mem_rdy, br_valid, br_target, ir_ready
   );

endinterface

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: reads two big-endian bytes per instruction and hands the
// 16-bit word to execute over valid/ready, with branch redirect and an issue counter.
module ifetch_seq
   import cpu16_pkg::*;
#(
   parameter int unsigned     PC_W     = 16,
   parameter int unsigned     ICNT_W   = 16,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
   input logic          ck,
   input logic          rst,
   ifetch_seq_if.master bus
);

   fetch_state_e       state_q;
   logic [PC_W-1:0]    pc_q;
   logic [PC_W-1:0]    ir_pc_q;
   logic [BYTE_W-1:0]  hi_q;
   logic [INSTR_W-1:0] ir_q;
   logic               ir_valid_q;
   logic [ICNT_W-1:0]  icnt_q;
   logic               handshake;

   assign handshake = (state_q == FS_OUT) && ir_valid_q && bus.ir_ready;

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_q    <= FS_HI;
         pc_q       <= RESET_PC;
         ir_pc_q    <= '0;
         hi_q       <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         icnt_q     <= '0;
      end else begin
         // A handshake coinciding with a redirect still counts as issued.
         if (handshake) begin
            icnt_q <= icnt_q + ICNT_W'(1);
         end
         if (bus.br_valid) begin
            pc_q       <= {bus.br_target[PC_W-1:1], 1'b0};
            state_q    <= FS_HI;
            ir_valid_q <= 1'b0;
         end else begin
            unique case (state_q)
               FS_HI: begin
                  if (bus.mem_rdy) begin
                     hi_q    <= bus.mem_data;
                     state_q <= FS_LO;
                  end
               end
               FS_LO: begin
                  if (bus.mem_rdy) begin
                     ir_q       <= {hi_q, bus.mem_data};
                     ir_pc_q    <= pc_q;
                     pc_q       <= pc_q + PC_W'(2);
                     ir_valid_q <= 1'b1;
                     state_q    <= FS_OUT;
                  end
               end
               FS_OUT: begin
                  if (handshake) begin
                     ir_valid_q <= 1'b0;
                     state_q    <= FS_HI;
                  end
               end
               default: state_q <= FS_HI;
            endcase
         end
      end
   end

   always_comb begin
      bus.mem_rd   = 1'b0;
      bus.mem_addr = pc_q;
      case (state_q)
         FS_HI: bus.mem_rd = 1'b1;
         FS_LO: begin
            bus.mem_rd   = 1'b1;
            bus.mem_addr = pc_q + PC_W'(1);
         end
         default: ;
      endcase
   end

   assign bus.ir       = ir_q;
   assign bus.ir_pc    = ir_pc_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.pc       = pc_q;
   assign bus.icnt     = icnt_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// Scoreboard bench for ifetch_seq: a default instance plus a wrap instance at pc fffe
// with a 4-bit issue counter.
module tb_ifetch_seq;

   typedef struct packed {
      logic [15:0] ir;
      logic [15:0] pc;
   } exp_t;

   logic ck;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] mem [65536];
   exp_t sb_q[$];
   exp_t sb_w[$];

   ifetch_seq_if #(.PC_W(16), .ICNT_W(16)) bus ();
   ifetch_seq_if #(.PC_W(16), .ICNT_W(4))  bus_w ();

   ifetch_seq #(.PC_W(16), .ICNT_W(16), .RESET_PC(16'h0000)) dut (
      .ck (ck),
      .rst(rst),
      .bus(bus)
   );

   ifetch_seq #(.PC_W(16), .ICNT_W(4), .RESET_PC(16'hfffe)) dut_w (
      .ck (ck),
      .rst(rst),
      .bus(bus_w)
   );

   assign bus.mem_data   = mem[bus.mem_addr];
   assign bus_w.mem_data = mem[bus_w.mem_addr];

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic do_reset();
      @(posedge ck); #1;
      bus.mem_rdy     = 1'b1;
      bus.br_valid    = 1'b0;
      bus.br_target   = '0;
      bus.ir_ready    = 1'b0;
      bus_w.mem_rdy   = 1'b1;
      bus_w.br_valid  = 1'b0;
      bus_w.br_target = '0;
      bus_w.ir_ready  = 1'b0;
      sb_q.delete();
      sb_w.delete();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge ck); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.ir_valid !== 1'b0 || bus.icnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_valid_icnt: got valid=%0b icnt=%h want 0/0000", bus.ir_valid, bus.icnt);
      end
      checks++;
      if (bus.ir !== 16'h0 || bus.ir_pc !== 16'h0) begin
         errors++;
         $display("FAIL reset_ir: got ir=%h ir_pc=%h want 0000/0000", bus.ir, bus.ir_pc);
      end
      checks++;
      if (bus.pc !== 16'h0 || bus.mem_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_pc: got pc=%h addr=%h want 0000/0000", bus.pc, bus.mem_addr);
      end
      checks++;
      if (bus_w.pc !== 16'hfffe || bus_w.mem_addr !== 16'hfffe) begin
         errors++;
         $display("FAIL reset_pc_w: got pc=%h addr=%h want fffe/fffe", bus_w.pc, bus_w.mem_addr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.mem_rd !== 1'b1) begin
         errors++;
         $display("FAIL reset_mem_rd: got %0b want 1", bus.mem_rd);
      end
   endtask

   task automatic test_basic();
      int   cyc;
      int   nhs;
      exp_t e;
      cyc = 0;
      nhs = 0;
      do_reset();
      sb_q.push_back({16'h01a2, 16'h0000});
      sb_q.push_back({16'h0426, 16'h0002});
      sb_q.push_back({16'h0bc9, 16'h0004});
      sb_q.push_back({16'h08ef, 16'h0006});
      bus.ir_ready = 1'b1;
      while (nhs < 4 && cyc < 40) begin
         @(posedge ck); #1;
         cyc++;
         if (bus.ir_valid === 1'b1) begin
            checks++;
            if (cyc != 2 + 3 * nhs) begin
               errors++;
               $display("FAIL basic_timing: valid at cycle %0d want %0d", cyc, 2 + 3 * nhs);
            end
            e = sb_q.pop_front();
            checks++;
            if (bus.ir !== e.ir || bus.ir_pc !== e.pc) begin
               errors++;
               $display("FAIL basic_ir: got %h@%h want %h@%h", bus.ir, bus.ir_pc, e.ir, e.pc);
            end
            nhs++;
         end
      end
      if (nhs < 4) begin
         errors++;
         $display("FAIL basic_timeout: got %0d handshakes want 4", nhs);
      end
      @(posedge ck); #1;
      checks++;
      if (bus.icnt !== 16'd4 || bus.pc !== 16'h0008 || bus.ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_end: got icnt=%0d pc=%h valid=%0b want 4/0008/0",
                  bus.icnt, bus.pc, bus.ir_valid);
      end
   endtask

   task automatic test_backpressure();
      logic found;
      exp_t e;
      do_reset();
      sb_q.push_back({16'h01a2, 16'h0000});
      sb_q.push_back({16'h0426, 16'h0002});
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge ck); #1;
         if (bus.ir_valid === 1'b1) found = 1'b1;
      end
      e = sb_q.pop_front();
      checks++;
      if (!found || bus.ir !== e.ir || bus.ir_pc !== e.pc) begin
         errors++;
         $display("FAIL bp_first: got %h@%h found=%0b want %h@%h", bus.ir, bus.ir_pc, found, e.ir, e.pc);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge ck); #1;
         checks++;
         if (bus.ir !== 16'h01a2 || bus.icnt !== 16'h0 || bus.mem_rd !== 1'b0 ||
             bus.ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got ir=%h icnt=%0d rd=%0b valid=%0b want 01a2/0/0/1",
                     bus.ir, bus.icnt, bus.mem_rd, bus.ir_valid);
         end
      end
      bus.ir_ready = 1'b1;
      @(posedge ck); #1;
      checks++;
      if (bus.icnt !== 16'd1 || bus.ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_handshake: got icnt=%0d valid=%0b want 1/0", bus.icnt, bus.ir_valid);
      end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge ck); #1;
         if (bus.ir_valid === 1'b1) found = 1'b1;
      end
      e = sb_q.pop_front();
      checks++;
      if (!found || bus.ir !== e.ir || bus.ir_pc !== e.pc) begin
         errors++;
         $display("FAIL bp_next: got %h@%h found=%0b want %h@%h", bus.ir, bus.ir_pc, found, e.ir, e.pc);
      end
      bus.ir_ready = 1'b0;
   endtask

   task automatic test_stall();
      logic found;
      exp_t e;
      do_reset();
      bus.ir_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(posedge ck); #1;
         if (bus.mem_addr === 16'h0003 && bus.mem_rd === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL stall_reach_lo: got addr=%h want 0003", bus.mem_addr);
      end
      bus.mem_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge ck); #1;
         checks++;
         if (bus.mem_addr !== 16'h0003 || bus.ir_valid !== 1'b0 || bus.icnt !== 16'd1) begin
            errors++;
            $display("FAIL stall_hold: got addr=%h valid=%0b icnt=%0d want 0003/0/1",
                     bus.mem_addr, bus.ir_valid, bus.icnt);
         end
      end
      bus.mem_rdy = 1'b1;
      sb_q.push_back({16'h0426, 16'h0002});
      @(posedge ck); #1;
      e = sb_q.pop_front();
      checks++;
      if (bus.ir_valid !== 1'b1 || bus.ir !== e.ir || bus.ir_pc !== e.pc) begin
         errors++;
         $display("FAIL stall_resume: got %h@%h valid=%0b want %h@%h valid=1",
                  bus.ir, bus.ir_pc, bus.ir_valid, e.ir, e.pc);
      end
   endtask

   task automatic test_redirect();
      logic found;
      int   cyc;
      exp_t e;
      do_reset();
      bus.ir_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(posedge ck); #1;
         if (bus.mem_addr === 16'h0001 && bus.mem_rd === 1'b1) found = 1'b1;
      end
      bus.br_valid  = 1'b1;
      bus.br_target = 16'h0005;
      sb_q.push_back({16'h0bc9, 16'h0004});
      @(posedge ck); #1;
      bus.br_valid = 1'b0;
      checks++;
      if (!found || bus.mem_addr !== 16'h0004 || bus.pc !== 16'h0004 || bus.ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_lo: got addr=%h pc=%h valid=%0b found=%0b want 0004/0004/0",
                  bus.mem_addr, bus.pc, bus.ir_valid, found);
      end
      found = 1'b0;
      cyc = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge ck); #1;
         cyc++;
         if (bus.ir_valid === 1'b1) found = 1'b1;
      end
      e = sb_q.pop_front();
      checks++;
      if (!found || cyc != 2 || bus.ir !== e.ir || bus.ir_pc !== e.pc || bus.icnt !== 16'h0) begin
         errors++;
         $display("FAIL redir_fetch: got %h@%h cyc=%0d icnt=%0d want %h@%h cyc=2 icnt=0",
                  bus.ir, bus.ir_pc, cyc, bus.icnt, e.ir, e.pc);
      end
      // Redirect while the handshake completes in OUT.
      bus.br_valid  = 1'b1;
      bus.br_target = 16'h0003;
      sb_q.push_back({16'h0426, 16'h0002});
      @(posedge ck); #1;
      bus.br_valid = 1'b0;
      checks++;
      if (bus.icnt !== 16'd1 || bus.ir_valid !== 1'b0 || bus.mem_addr !== 16'h0002) begin
         errors++;
         $display("FAIL redir_out: got icnt=%0d valid=%0b addr=%h want 1/0/0002",
                  bus.icnt, bus.ir_valid, bus.mem_addr);
      end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge ck); #1;
         if (bus.ir_valid === 1'b1) found = 1'b1;
      end
      e = sb_q.pop_front();
      checks++;
      if (!found || bus.ir !== e.ir || bus.ir_pc !== e.pc) begin
         errors++;
         $display("FAIL redir_target: got %h@%h found=%0b want %h@%h", bus.ir, bus.ir_pc, found, e.ir, e.pc);
      end
      bus.ir_ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [15:0] a;
      logic [15:0] a1;
      int          cyc;
      int          nhs;
      exp_t        e;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         a  = 16'hfffe + 16'(2 * k);
         a1 = a + 16'd1;
         sb_w.push_back({mem[a], mem[a1], a});
      end
      bus_w.ir_ready = 1'b1;
      cyc = 0;
      nhs = 0;
      while (nhs < 16 && cyc < 100) begin
         @(posedge ck); #1;
         cyc++;
         if (bus_w.ir_valid === 1'b1) begin
            e = sb_w.pop_front();
            checks++;
            if (bus_w.ir !== e.ir || bus_w.ir_pc !== e.pc || bus_w.icnt !== 4'(nhs)) begin
               errors++;
               $display("FAIL wrap_ir: got %h@%h icnt=%0d want %h@%h icnt=%0d",
                        bus_w.ir, bus_w.ir_pc, bus_w.icnt, e.ir, e.pc, nhs % 16);
            end
            if (nhs == 0) begin
               checks++;
               if (bus_w.pc !== 16'h0000) begin
                  errors++;
                  $display("FAIL wrap_pc: got %h want 0000", bus_w.pc);
               end
            end
            nhs++;
         end
      end
      @(posedge ck); #1;
      checks++;
      if (nhs != 16 || bus_w.icnt !== 4'h0) begin
         errors++;
         $display("FAIL wrap_icnt: got icnt=%0d handshakes=%0d want 0/16", bus_w.icnt, nhs);
      end
      bus_w.ir_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      logic found;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge ck); #1;
         if (bus.ir_valid === 1'b1) found = 1'b1;
      end
      bus.ir_ready = 1'b1;
      @(posedge ck); #1;
      bus.ir_ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge ck); #1;
         if (bus.ir_valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || bus.icnt !== 16'd1 || bus.ir !== 16'h0426) begin
         errors++;
         $display("FAIL areset_pre: got icnt=%0d ir=%h found=%0b want 1/0426/1", bus.icnt, bus.ir, found);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.ir_valid !== 1'b0 || bus.icnt !== 16'h0 || bus.ir !== 16'h0 ||
          bus.pc !== 16'h0 || bus.ir_pc !== 16'h0) begin
         errors++;
         $display("FAIL areset: got valid=%0b icnt=%0d ir=%h pc=%h ir_pc=%h want all 0",
                  bus.ir_valid, bus.icnt, bus.ir, bus.pc, bus.ir_pc);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      bus.mem_rdy     = 1'b1;
      bus.br_valid    = 1'b0;
      bus.br_target   = '0;
      bus.ir_ready    = 1'b0;
      bus_w.mem_rdy   = 1'b1;
      bus_w.br_valid  = 1'b0;
      bus_w.br_target = '0;
      bus_w.ir_ready  = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7) + 3);
      mem[0] = 8'h01; mem[1] = 8'ha2; mem[2] = 8'h04; mem[3] = 8'h26;
      mem[4] = 8'h0b; mem[5] = 8'hc9; mem[6] = 8'h08; mem[7] = 8'hef;
      mem[16'hfffe] = 8'h12;
      mem[16'hffff] = 8'h34;
      test_reset();
      test_basic();
      test_backpressure();
      test_stall();
      test_redirect();
      test_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
Instruction fetch sequencer for the cpu16 core.
- Owns the PC and reads two consecutive bytes from the byte-wide instruction memory, high byte at pc and low byte at pc+1 (big-endian).
- Presents the assembled 16-bit instruction to the decode/execute stage over a valid/ready handshake.
- Counts issued instructions (ICNT) and accepts branch redirects from execute.

Parameters:
PC_W, 16, width of PC and memory byte address
ICNT_W, 16, width of issued-instruction counter
RESET_PC, 0, PC value loaded on reset

Ports:
ck  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
mem_addr  output  PC_W  byte address to instruction memory
mem_rd  output  1  read strobe, high in HI and LO states
mem_data  input  8  read data, combinational from mem_addr
mem_rdy  input  1  memory data valid this cycle; low = stall
br_valid  input  1  redirect request from execute
br_target  input  PC_W  redirect byte address
ir  output  16  fetched instruction {hi,lo}
ir_pc  output  PC_W  address of instruction in ir
ir_valid  output  1  ir holds an unconsumed instruction
ir_ready  input  1  consumer accepts ir this cycle
pc  output  PC_W  next fetch address
icnt  output  ICNT_W  instructions handed off since reset

Behaviour:
- Clock port is ck; reset port is rst, asynchronous and active-high. Reset forces all state immediately, with no clock required.
- Reset values:
  - pc = RESET_PC, state = HI
  - ir = 0, ir_pc = 0, ir_valid = 0, icnt = 0
  - mem_rd = 1 once rst is low, mem_addr = RESET_PC
  - The internal hi-byte register resets to 0.
- FSM states are HI, LO, OUT.
- HI: mem_addr = pc, mem_rd = 1.
  - If mem_rdy: hi_byte <= mem_data, go to LO.
  - Otherwise hold.
- LO: mem_addr = pc+1 (mod 2^PC_W), mem_rd = 1.
  - If mem_rdy: ir <= {hi_byte, mem_data}, ir_pc <= pc, pc <= pc+2 (mod 2^PC_W), ir_valid <= 1, go to OUT.
  - Otherwise hold.
- OUT: mem_rd = 0, mem_addr = pc. ir, ir_pc and ir_valid are held stable.
  - When ir_valid and ir_ready: icnt <= icnt+1 (wraps at 2^ICNT_W), ir_valid <= 0, go to HI.
- Latency and throughput:
  - With mem_rdy stuck at 1, ir_valid rises after the 2nd rising edge following entry to HI.
  - With ir_ready stuck at 1, throughput is one instruction per 3 cycles.
- ir_valid never drops without a handshake, except on redirect or reset.
- Redirect (br_valid = 1 at an edge) has priority over all fetch activity in every state:
  - pc <= {br_target[PC_W-1:1], 1'b0}, i.e. the LSB is forced to 0 so fetches are always halfword-aligned.
  - state <= HI and ir_valid <= 0.
  - Any captured hi_byte is discarded. ir and ir_pc keep their old values, which are don't-care.
- Redirect in OUT coinciding with ir_valid & ir_ready: the handshake completes (icnt increments) and the redirect also applies.
- Redirect in OUT without ready: the pending instruction is dropped and icnt is unchanged.
- mem_rdy low in HI/LO: no state change, mem_addr held, icnt unchanged.
- PC wrap: pc = 2^PC_W-2 fetches bytes FFFE, FFFF, then pc becomes 0. No error flag.
- Reset asserted mid-fetch or mid-handshake: immediate return to reset values, and the partial instruction is lost.
- ir_ready while ir_valid = 0 is ignored.

Decomposition:
- Shared package cpu16_pkg holds:
  - INSTR_W = 16 and BYTE_W = 8
  - the fetch-state enum (FS_HI, FS_LO, FS_OUT)
  - the default RESET_PC
- No sub-module is needed: a single module with one FSM, the pc/icnt registers and the ir register.

Test Plan:
- Basic stream:
  - Stimulus: memory bytes 0..7 = 01 a2 04 26 0b c9 08 ef; mem_rdy = 1; ir_ready = 1; rst pulsed then released.
  - Required: ir = 01a2, 0426, 0bc9, 08ef with ir_pc = 0, 2, 4, 6.
  - Required: icnt = 4 and pc = 8 after the 4th handshake; ir_valid high 1 cycle of every 3.
- Backpressure:
  - Stimulus: same memory; ir_ready = 0 for 5 cycles after the first ir_valid.
  - Required: ir = 01a2 held stable, icnt = 0, mem_rd = 0.
  - Required: after ir_ready rises, one handshake, icnt = 1, next ir = 0426.
- Memory stall:
  - Stimulus: mem_rdy = 0 for 3 cycles while in LO at pc = 2.
  - Required: mem_addr held at 3 and no ir_valid.
  - Required: after mem_rdy returns, ir = 0426 with ir_pc = 2.
- Redirect:
  - Stimulus: br_valid with br_target = 5 while in LO fetching pc = 0.
  - Required: hi byte discarded, next mem_addr = 4, next ir = 0bc9 with ir_pc = 4, icnt unchanged.
  - Stimulus: br_valid in OUT together with ir_ready.
  - Required: icnt increments and the fetch restarts at the target.
- Wrap:
  - Stimulus: RESET_PC = 16'hfffe; bytes fffe = 12, ffff = 34, 0000 = 01.
  - Required: ir = 1234, ir_pc = fffe, pc = 0.
  - Stimulus: icnt preforced to ffff, then one handshake.
  - Required: icnt = 0.
- Async reset:
  - Stimulus: rst asserted between clock edges while ir_valid = 1.
  - Required: ir_valid, icnt and ir go to 0 and pc goes to RESET_PC before the next ck edge.
